// File: rtl/m2_port_arbiter.sv
// Two-port req/gnt arbiter sharing the m2 scratchpad port between the input pipeline (port 0)
// and the CDF engine (port 1). Define ARB_STATS_EN to add per-port wait-cycle counters.
module m2_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int WDATA_W  = 128,
  parameter int RDATA_W  = 36,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 64
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               lock0,
  input  logic               lock1,
  input  logic               rd_en0,
  input  logic               rd_en1,
  input  logic               we0,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  raddr0,
  input  logic [ADDR_W-1:0]  raddr1,
  input  logic [ADDR_W-1:0]  waddr0,
  input  logic [ADDR_W-1:0]  waddr1,
  input  logic [WDATA_W-1:0] wdata0,
  input  logic [WDATA_W-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [RDATA_W-1:0] m2_rdata_o,
  input  logic [RDATA_W-1:0] m2_rdata_i,
  output logic [ADDR_W-1:0]  m2_raddr,
  output logic [ADDR_W-1:0]  m2_waddr,
  output logic [WDATA_W-1:0] m2_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]        wait_cnt0,
  output logic [15:0]        wait_cnt1,
`endif
  output logic               m2_we
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;     // 1: port 1 was served last
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                other_wait;
  logic [RD_LAT-1:0][1:0] tag_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                                      state_d = req1 ? OWN1 : IDLE;
        else if (req1 && (hold_q == HOLD_MAX) && !lock0) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                                      state_d = req0 ? OWN0 : IDLE;
        else if (req0 && (hold_q == HOLD_MAX) && !lock1) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == OWN0) && (state_d != OWN0)) last_d = 1'b0;
    if ((state_q == OWN1) && (state_d != OWN1)) last_d = 1'b1;
  end

  assign other_wait = ((state_q == OWN0) && req1) || ((state_q == OWN1) && req0);

  // Hold counter measures how long the non-owner has been kept waiting under the current grant.
  always_comb begin
    hold_d = hold_q;
    if ((state_d != state_q) || !other_wait) hold_d = '0;
    else if (hold_q != HOLD_MAX)             hold_d = hold_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);

  // Memory side follows the registered grant; a non-granted port's strobes are dropped.
  always_comb begin
    m2_raddr = '0;
    m2_waddr = '0;
    m2_wdata = '0;
    m2_we    = 1'b0;
    if (gnt0) begin
      m2_raddr = raddr0;
      m2_waddr = waddr0;
      m2_wdata = wdata0;
      m2_we    = we0;
    end else if (gnt1) begin
      m2_raddr = raddr1;
      m2_waddr = waddr1;
      m2_wdata = wdata1;
      m2_we    = we1;
    end
  end

  // NOTE: the read-tag pipe is reset (unlike a data RAM) so reads in flight at reset never return.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= {gnt1 & rd_en1, gnt0 & rd_en0};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rvalid0    = tag_q[RD_LAT-1][0];
  assign rvalid1    = tag_q[RD_LAT-1][1];
  assign m2_rdata_o = m2_rdata_i;

`ifdef ARB_STATS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt0 <= '0;
      wait_cnt1 <= '0;
    end else begin
      if (req0 && !gnt0 && (wait_cnt0 != 16'hFFFF)) wait_cnt0 <= wait_cnt0 + 16'd1;
      if (req1 && !gnt1 && (wait_cnt1 != 16'hFFFF)) wait_cnt1 <= wait_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m2_port_arbiter.sv
// Directed bench for m2_port_arbiter (RD_LAT=2, MAX_HOLD=64): grant checks inline,
// memory-side writes and tagged read returns checked by a scoreboard monitor.
module tb_m2_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int WDATA_W = 128;
  localparam int RDATA_W = 36;

  logic               clock = 1'b0;
  logic               rst_n;
  logic               req0, req1, lock0, lock1, rd_en0, rd_en1, we0, we1;
  logic [ADDR_W-1:0]  raddr0, raddr1, waddr0, waddr1;
  logic [WDATA_W-1:0] wdata0, wdata1;
  logic               gnt0, gnt1, rvalid0, rvalid1, m2_we;
  logic [RDATA_W-1:0] m2_rdata_o, m2_rdata_i;
  logic [ADDR_W-1:0]  m2_raddr, m2_waddr;
  logic [WDATA_W-1:0] m2_wdata;
`ifdef ARB_STATS_EN
  logic [15:0]        wait_cnt0, wait_cnt1;
`endif

  m2_port_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W),
                    .RD_LAT(2), .MAX_HOLD(64)) dut (
    .clock(clock), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rd_en0(rd_en0), .rd_en1(rd_en1), .we0(we0), .we1(we1),
    .raddr0(raddr0), .raddr1(raddr1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .m2_rdata_o(m2_rdata_o), .m2_rdata_i(m2_rdata_i),
    .m2_raddr(m2_raddr), .m2_waddr(m2_waddr), .m2_wdata(m2_wdata),
`ifdef ARB_STATS_EN
    .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1),
`endif
    .m2_we(m2_we)
  );

  always #5 clock = ~clock;

  // Two-cycle memory model: data for an address appears two cycles after it is presented.
  logic [ADDR_W-1:0] mem_p1, mem_p2;
  always @(posedge clock) begin
    mem_p1 <= m2_raddr;
    mem_p2 <= mem_p1;
  end
  assign m2_rdata_i = {4'hA, mem_p2, ~mem_p2};

  function automatic logic [RDATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    return {4'hA, a, ~a};
  endfunction

  typedef struct { logic [ADDR_W-1:0] addr; logic [WDATA_W-1:0] data; } wr_t;
  typedef struct { logic port; logic [RDATA_W-1:0] data; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [WDATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic push_rd(input logic p, input logic [ADDR_W-1:0] a);
    rd_t r;
    r.port = p;
    r.data = rd_word(a);
    rq.push_back(r);
  endtask

  // Monitor: every issued write and every read return must match the next expected entry.
  always @(negedge clock) begin
    if (rst_n) begin
      if (m2_we) begin
        n_checks++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %0h with no write expected", m2_waddr);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (m2_waddr !== w.addr || m2_wdata !== w.data) begin
            n_err++;
            $display("FAIL write_data: got addr %0h data %0h expected addr %0h data %0h",
                     m2_waddr, m2_wdata, w.addr, w.data);
          end
        end
      end
      if (rvalid0 || rvalid1) begin
        n_checks++;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rvalid: got rvalid %b%b with no read expected", rvalid1, rvalid0);
        end else begin
          rd_t r;
          r = rq.pop_front();
          if ({rvalid1, rvalid0} !== (r.port ? 2'b10 : 2'b01) || m2_rdata_o !== r.data) begin
            n_err++;
            $display("FAIL read_return: got rvalid %b%b data %0h expected port %0d data %0h",
                     rvalid1, rvalid0, m2_rdata_o, r.port, r.data);
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [3:0] we_pat;
    rst_n = 1'b0;
    {req0, req1, lock0, lock1, rd_en0, rd_en1, we0, we1} = '0;
    raddr0 = '0; raddr1 = '0; waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
    #12;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_we", m2_we, 1'b0);
    check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    check("rst_raddr", m2_raddr, 16'h0);
    check("rst_wdata", m2_wdata, 128'h0);
    @(posedge clock);
    #1 rst_n = 1'b1;

    // T2: simultaneous requests after reset -> port 0 first, gap-free handover
    req0 = 1'b1; req1 = 1'b1;
    #1 check("t2_no_gnt_same_cycle", {gnt1, gnt0}, 2'b00);
    step();
    check("t2_gnt0_first", {gnt1, gnt0}, 2'b01);
    step(); step();
    check("t2_gnt0_held", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    step();
    check("t2_handover", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    step();
    check("t2_idle", {gnt1, gnt0}, 2'b00);

    // T1: port 0 alone, 8 writes
    req0 = 1'b1;
    step();
    check("t1_gnt0", {gnt1, gnt0}, 2'b01);
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1;
      waddr0 = 16'h0100 + 16'(i);
      wdata0 = {16{8'(8'hA0 + i)}};
      push_wr(waddr0, wdata0);
      #1 check("t1_gnt1_low", gnt1, 1'b0);
      step();
    end
    we0 = 1'b0;
    #1 check("t1_we_off", m2_we, 1'b0);
    req0 = 1'b0;
    step();
    check("t1_release", {gnt1, gnt0}, 2'b00);

    // T5: port 1 write attempts while port 0 owns are not issued
    req0 = 1'b1;
    step();
    check("t5_gnt0", {gnt1, gnt0}, 2'b01);
    req1 = 1'b1; we1 = 1'b1; waddr1 = 16'hBEEF; wdata1 = {4{32'hDEAD_BEEF}};
    we_pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      we0 = we_pat[i];
      waddr0 = 16'h0200 + 16'(i);
      wdata0 = {8{16'(16'h5500 + i)}};
      if (we0) push_wr(waddr0, wdata0);
      #1 check("t5_we_tracks_we0", m2_we, we_pat[i]);
      step();
    end
    we0 = 1'b0; we1 = 1'b0; req0 = 1'b0;
    step();
    check("t5_handover", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    step();

    // T4: read on port 0's last granted cycle returns to port 0 after handover
    req0 = 1'b1;
    step();
    check("t4_gnt0", {gnt1, gnt0}, 2'b01);
    req1 = 1'b1; req0 = 1'b0;
    rd_en0 = 1'b1; raddr0 = 16'h0010;
    rd_en1 = 1'b1; raddr1 = 16'h0020;
    push_rd(1'b0, 16'h0010);
    step();
    check("t4_gnt1", {gnt1, gnt0}, 2'b10);
    rd_en0 = 1'b0; raddr1 = 16'h0030;
    push_rd(1'b1, 16'h0030);
    step();
    rd_en1 = 1'b0;
    #1 check("t4_rvalid0_lat2", {rvalid1, rvalid0}, 2'b01);
    step();
    check("t4_rvalid1_lat2", {rvalid1, rvalid0}, 2'b10);
    req1 = 1'b0;
    step(); step();

    // T3: pre-emption after 64 waiting cycles, then lock blocks it for 200 cycles
    req0 = 1'b1;
    step();
    check("t3_gnt0", {gnt1, gnt0}, 2'b01);
    req1 = 1'b1;
    step();
    n = 1;
    while (!gnt1 && n < 200) begin
      step();
      n++;
    end
    check("t3_preempt_cycles", n, 64);
    check("t3_owner_dropped", gnt0, 1'b0);
    req1 = 1'b0;
    step();
    check("t3_rewin", {gnt1, gnt0}, 2'b01);
    lock0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (gnt0 && !gnt1) n++;
    end
    check("t3_lock_held", n, 200);
    lock0 = 1'b0;
    step();
    check("t3_unlock_preempt", {gnt1, gnt0}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // T6: async reset mid-burst, then recovery
    req0 = 1'b1;
    step();
    we0 = 1'b1; waddr0 = 16'h0300; wdata0 = {4{32'h1234_5678}};
    rd_en0 = 1'b1; raddr0 = 16'h0040;
    push_wr(waddr0, wdata0);
    step();
    waddr0 = 16'h0301; wdata0 = {4{32'h8765_4321}}; raddr0 = 16'h0041;
    push_wr(waddr0, wdata0);
    step();
    rd_en0 = 1'b0; waddr0 = 16'h0302;
    #1 check("t6_rvalid_before_rst", rvalid0, 1'b1);
    check("t6_we_before_rst", m2_we, 1'b1);
    rst_n = 1'b0;
    #1 check("t6_rst_gnt", {gnt1, gnt0}, 2'b00);
    check("t6_rst_we", m2_we, 1'b0);
    check("t6_rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    req0 = 1'b0; we0 = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
    req1 = 1'b1;
    #1 check("t6_no_gnt_yet", gnt1, 1'b0);
    step();
    check("t6_gnt1_after_rst", {gnt1, gnt0}, 2'b10);
`ifdef ARB_STATS_EN
    check("t6_wait_cnt1_first", wait_cnt1, 16'd1);
`endif
    req1 = 1'b0;
    step();
    req0 = 1'b1;
    step();
    req1 = 1'b1;
    repeat (4) step();
    req0 = 1'b0;
    step();
    check("t6_stall_handover", {gnt1, gnt0}, 2'b10);
`ifdef ARB_STATS_EN
    check("t6_wait_cnt1_stall", wait_cnt1, 16'd6);
    check("t6_wait_cnt0", wait_cnt0, 16'd1);
`endif
    req1 = 1'b0;
    repeat (4) step();
    check("wr_queue_drained", wq.size(), 0);
    check("rd_queue_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
